apb_reg_slave: RTL and testbench
================================

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter SLV_ID, default 0, meaning the index (0..2) of the pselx bit that selects this slave.
REQ-002 SHALL have parameter RESET_VAL, default 32'h0, meaning the reset value of general registers R0..R13.
REQ-003 SHALL have port hclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port hresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port pselx, input, 3 bits: one-hot APB select; this slave uses bit SLV_ID only (psel).
REQ-006 SHALL have port penable, input, 1 bit: APB access-phase strobe.
REQ-007 SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port paddr, input, 32 bits: byte address; word index = paddr[5:2]; all other bits ignored.
REQ-009 SHALL have port pwdata, input, 32 bits: write data.
REQ-010 SHALL have port prdata, output, 32 bits: read data.
REQ-011 SHALL have port perr_irq, output, 1 bit: sticky protocol-error flag.

Function
REQ-012 SHALL implement 16 word locations: R0..R13 general read/write, R14 STATUS, R15 WCOUNT.
REQ-013 SHALL track the bus with a 3-state FSM: IDLE (psel=0), SETUP (psel=1, penable=0), ACCESS (psel=1, penable=1).
REQ-014 SHALL transition IDLE->SETUP on psel=1 with penable=0; SETUP->ACCESS on psel=1 with penable=1; ACCESS->SETUP on psel=1 with penable=0 (back-to-back); ACCESS->IDLE on psel=0; otherwise hold or return to IDLE as the psel/penable levels dictate.
REQ-015 SHALL latch paddr[5:2] and pwrite at every IDLE->SETUP and ACCESS->SETUP transition.
REQ-016 SHALL flag a protocol error on any of: penable=1 while the FSM is in IDLE; psel dropping while in SETUP; paddr[5:2] or pwrite differing from the latched values while in ACCESS.
REQ-017 SHALL, on a protocol error, complete no write, set STATUS[0] (ERR), and move the FSM to IDLE if psel=0, otherwise to SETUP.
REQ-018 SHALL commit a write on the rising edge at which psel=1, penable=1, pwrite=1, the FSM is in SETUP, and no error is flagged: exactly one commit per ACCESS cycle, zero wait states.
REQ-019 SHALL, on a write to R0..R13, store pwdata in full.
REQ-020 SHALL, on a write to R14, clear ERR only if pwdata[0]=1; all other bits are ignored.
REQ-021 SHALL ignore the data of any write to R15.
REQ-022 SHALL increment WCOUNT (16 bits, wrapping 16'hFFFF->16'h0000) by one on every committed write to any index, R14 and R15 included.
REQ-023 SHALL give ERR-set priority over ERR-clear when both occur on the same edge.
REQ-024 SHALL drive prdata combinationally to the addressed word when psel=1, penable=1 and pwrite=0, and to 32'h0 at all other times.
REQ-025 SHALL read R14 as {30'b0, fsm_in_access, ERR} and R15 as {16'b0, WCOUNT}.
REQ-026 SHALL drive perr_irq = ERR, registered.
REQ-027 SHALL let reads never modify state.
REQ-028 SHALL ignore pselx bits other than SLV_ID entirely; when more than one pselx bit is set, it SHALL still respond to bit SLV_ID.

Reset
REQ-029 SHALL, while hresetn=0 and independent of hclk, force FSM=IDLE, R0..R13=RESET_VAL, ERR=0, WCOUNT=0, latched address/direction=0 and perr_irq=0.
REQ-030 SHALL, on reset mid-transfer, abort the transfer with no write and restart cleanly on the first edge after hresetn rises.
REQ-031 SHALL show prdata=0 during reset because it is combinational and psel/penable gate it.

Verification
REQ-032 Bench SHALL cover: SLV_ID=0, write R3 with pwdata=32'hA5A5_1234 (SETUP then ACCESS), then read R3 -> prdata=32'hA5A5_1234 in the read ACCESS cycle; WCOUNT reads 16'h0001.
REQ-033 Bench SHALL cover: back-to-back writes R0=1, R1=2, R2=3 with no IDLE between -> each committed once; WCOUNT=3; perr_irq stays 0.
REQ-034 Bench SHALL cover: penable=1 with psel asserted and no prior SETUP -> no write; perr_irq=1 on the next edge; STATUS reads 32'h1.
REQ-035 Bench SHALL cover: with ERR=1, write R14 pwdata=32'h1 -> perr_irq=0 after the commit edge; WCOUNT increments; write R14 pwdata=32'h0 leaves ERR unchanged.
REQ-036 Bench SHALL cover: WCOUNT preloaded via 65535 writes, one more write -> WCOUNT=0; write R15 pwdata=32'hFFFF_FFFF -> data ignored, WCOUNT=1.
REQ-037 Bench SHALL cover: hresetn low asynchronously in the middle of a write ACCESS to R5 -> R5=RESET_VAL, no WCOUNT change; pselx=3'b010 with SLV_ID=0 -> no state change and prdata=0.

Source files
------------

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle for the register slave.
// Master drives the select/strobe/address/data, slave returns read data and irq.
interface apb_reg_slave_if;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        perr_irq;

    modport master (
        output pselx, penable, pwrite, paddr, pwdata,
        input  prdata, perr_irq
    );

    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata,
        output prdata, perr_irq
    );
endinterface

// File: rtl/apb_reg_slave.sv
// APB register slave: 14 general words, STATUS (R14), write counter (R15).
// Tracks the bus phase, flags protocol errors and commits zero-wait writes.
module apb_reg_slave #(
    parameter int          SLV_ID    = 0,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input logic             hclk,
    input logic             hresetn,
    apb_reg_slave_if.slave  apb
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic        psel;
    logic [3:0]  idx;
    logic [3:0]  addr_q;
    logic        wr_q;
    logic [31:0] regs_q [14];
    logic        err_q;
    logic [15:0] wcount_q;
    logic        proto_err;
    logic        commit;
    logic        latch;
    logic        rd_en;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign psel = apb.pselx[SLV_ID];
    assign idx  = apb.paddr[5:2];
    assign unused_bits = ^{apb.paddr[31:6], apb.paddr[1:0], apb.pselx};

    // A held ACCESS must keep the address and direction seen in SETUP
    always_comb begin
        proto_err = 1'b0;
        unique case (state_q)
            IDLE:    proto_err = psel && apb.penable;
            SETUP:   proto_err = !psel;
            ACCESS:  proto_err = psel && apb.penable &&
                                 (idx != addr_q || apb.pwrite != wr_q);
            default: proto_err = 1'b0;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (proto_err) begin
            state_d = psel ? SETUP : IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = (psel && !apb.penable) ? SETUP : IDLE;
                SETUP:   state_d = apb.penable ? ACCESS : SETUP;
                ACCESS:  state_d = !psel ? IDLE :
                                   (apb.penable ? ACCESS : SETUP);
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        commit = (state_q == SETUP) && psel && apb.penable &&
                 apb.pwrite && !proto_err;
        latch  = (state_d == SETUP) &&
                 (state_q == IDLE || state_q == ACCESS);
        rd_en  = psel && apb.penable && !apb.pwrite;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q <= 4'd0;
            wr_q   <= 1'b0;
        end else if (latch) begin
            addr_q <= idx;
            wr_q   <= apb.pwrite;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < 14; i++) regs_q[i] <= RESET_VAL;
        end else if (commit && idx < 4'd14) begin
            regs_q[idx] <= apb.pwdata;
        end
    end

    // Error set wins over a same-edge clear
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            err_q <= 1'b0;
        end else if (proto_err) begin
            err_q <= 1'b1;
        end else if (commit && idx == 4'd14 && apb.pwdata[0]) begin
            err_q <= 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)    wcount_q <= 16'h0;
        else if (commit) wcount_q <= wcount_q + 16'h1;
    end

    always_comb begin
        rd_word = 32'h0;
        unique case (1'b1)
            idx == 4'd14: rd_word = {30'b0, state_q == ACCESS, err_q};
            idx == 4'd15: rd_word = {16'b0, wcount_q};
            default:      rd_word = regs_q[idx];
        endcase
    end

    assign apb.prdata   = rd_en ? rd_word : 32'h0;
    assign apb.perr_irq = err_q;
endmodule

// File: tb/tb_apb_reg_slave.sv
// Randomized self-checking bench for apb_reg_slave against a word-level model.
module tb_apb_reg_slave;
    localparam logic [31:0] RV = 32'hC0DE_5A17;

    logic hclk;
    logic hresetn;
    int   n_checks;
    int   n_fail;

    logic [31:0] m_regs [14];
    logic        m_err;
    logic [15:0] m_wc;

    apb_reg_slave_if bus ();

    apb_reg_slave #(.SLV_ID(0), .RESET_VAL(RV)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .apb     (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic void m_reset();
        for (int i = 0; i < 14; i++) m_regs[i] = RV;
        m_err = 1'b0;
        m_wc  = 16'h0;
    endfunction

    function automatic logic [31:0] m_read(input int i);
        if (i < 14) return m_regs[i];
        if (i == 14) return {31'b0, m_err};
        return {16'b0, m_wc};
    endfunction

    function automatic void m_write(input int i, input logic [31:0] d);
        if (i < 14) m_regs[i] = d;
        else if (i == 14 && d[0]) m_err = 1'b0;
        m_wc = m_wc + 16'h1;
    endfunction

    task automatic bus_idle();
        @(negedge hclk);
        bus.pselx   = 3'b000;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    // SETUP then ACCESS; returns prdata sampled inside the ACCESS cycle
    task automatic apb_xfer(input logic wr, input logic [3:0] i,
                            input logic [31:0] wd,
                            output logic [31:0] rd);
        logic [31:0] a;
        logic [2:0]  s;
        a = $urandom;
        s = 3'($urandom);
        @(negedge hclk);
        bus.pselx   = s | 3'b001;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = {a[31:6], i, a[1:0]};
        bus.pwdata  = wd;
        @(negedge hclk);
        bus.penable = 1'b1;
        #1 rd = bus.prdata;
        if (wr) m_write(int'(i), wd);
    endtask

    task automatic do_reset();
        bus_idle();
        #2 hresetn = 1'b0;
        #1;
        n_checks++;
        if (bus.prdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_prdata got=%h exp=0", bus.prdata);
        end
        n_checks++;
        if (bus.perr_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_irq got=%b exp=0", bus.perr_irq);
        end
        @(negedge hclk);
        hresetn = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apb_xfer(1'b0, 4'(i), 32'h0, rd);
            n_checks++;
            if (rd !== m_read(i)) begin
                n_fail++;
                $display("FAIL rst_word%0d got=%h exp=%h", i, rd, m_read(i));
            end
        end
        bus_idle();
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        do_reset();
        apb_xfer(1'b1, 4'd3, 32'hA5A5_1234, rd);
        bus_idle();
        apb_xfer(1'b0, 4'd3, 32'h0, rd);
        n_checks++;
        if (rd !== 32'hA5A5_1234) begin
            n_fail++;
            $display("FAIL wr_r3 got=%h exp=a5a51234", rd);
        end
        bus_idle();
        apb_xfer(1'b0, 4'd15, 32'h0, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL wr_wcount got=%h exp=1", rd);
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apb_xfer(1'b1, 4'(i), 32'(i + 1), rd);
        end
        bus_idle();
        n_checks++;
        if (bus.perr_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_irq got=%b exp=0", bus.perr_irq);
        end
        for (int i = 0; i < 3; i++) begin
            apb_xfer(1'b0, 4'(i), 32'h0, rd);
            n_checks++;
            if (rd !== 32'(i + 1)) begin
                n_fail++;
                $display("FAIL b2b_r%0d got=%h exp=%h", i, rd, i + 1);
            end
        end
        apb_xfer(1'b0, 4'd15, 32'h0, rd);
        n_checks++;
        if (rd !== 32'h3) begin
            n_fail++;
            $display("FAIL b2b_wcount got=%h exp=3", rd);
        end
        bus_idle();
    endtask

    task automatic test_err_no_setup();
        logic [31:0] rd;
        @(negedge hclk);
        bus.pselx   = 3'b001;
        bus.penable = 1'b1;
        bus.pwrite  = 1'b1;
        bus.paddr   = 32'h10;
        bus.pwdata  = 32'h5555_AAAA;
        #1;
        n_checks++;
        if (bus.perr_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL nosetup_pre got=%b exp=0", bus.perr_irq);
        end
        @(negedge hclk);
        m_err = 1'b1;
        n_checks++;
        if (bus.perr_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL nosetup_irq got=%b exp=1", bus.perr_irq);
        end
        bus.pselx   = 3'b000;
        bus.penable = 1'b0;
        bus_idle();
        apb_xfer(1'b0, 4'd4, 32'h0, rd);
        n_checks++;
        if (rd !== m_regs[4]) begin
            n_fail++;
            $display("FAIL nosetup_r4 got=%h exp=%h", rd, m_regs[4]);
        end
        apb_xfer(1'b0, 4'd14, 32'h0, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL nosetup_status got=%h exp=1", rd);
        end
        apb_xfer(1'b0, 4'd15, 32'h0, rd);
        n_checks++;
        if (rd !== {16'b0, m_wc}) begin
            n_fail++;
            $display("FAIL nosetup_wc got=%h exp=%h", rd, m_wc);
        end
        bus_idle();
    endtask

    task automatic test_err_clear();
        logic [31:0] rd;
        apb_xfer(1'b1, 4'd14, 32'hFFFF_FFFE, rd);
        bus_idle();
        n_checks++;
        if (bus.perr_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL clr0_irq got=%b exp=1", bus.perr_irq);
        end
        apb_xfer(1'b1, 4'd14, 32'h1, rd);
        bus_idle();
        n_checks++;
        if (bus.perr_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL clr1_irq got=%b exp=0", bus.perr_irq);
        end
        apb_xfer(1'b0, 4'd15, 32'h0, rd);
        n_checks++;
        if (rd !== {16'b0, m_wc}) begin
            n_fail++;
            $display("FAIL clr_wc got=%h exp=%h", rd, m_wc);
        end
        bus_idle();
        // Address changes while ACCESS is held: error, no extra write
        apb_xfer(1'b1, 4'd2, 32'h0BAD_F00D, rd);
        @(negedge hclk);
        bus.paddr = 32'h24;
        @(negedge hclk);
        m_err = 1'b1;
        n_checks++;
        if (bus.perr_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL addrchg_irq got=%b exp=1", bus.perr_irq);
        end
        bus.pselx   = 3'b000;
        bus.penable = 1'b0;
        bus_idle();
        apb_xfer(1'b0, 4'd9, 32'h0, rd);
        n_checks++;
        if (rd !== m_regs[9]) begin
            n_fail++;
            $display("FAIL addrchg_r9 got=%h exp=%h", rd, m_regs[9]);
        end
        apb_xfer(1'b0, 4'd15, 32'h0, rd);
        n_checks++;
        if (rd !== {16'b0, m_wc}) begin
            n_fail++;
            $display("FAIL addrchg_wc got=%h exp=%h", rd, m_wc);
        end
        apb_xfer(1'b1, 4'd14, 32'h1, rd);
        bus_idle();
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] wd;
        logic [3:0]  i;
        logic        wr;
        for (int n = 0; n < 150; n++) begin
            wr = 1'($urandom);
            i  = 4'($urandom);
            wd = $urandom;
            apb_xfer(wr, i, wd, rd);
            n_checks++;
            if (!wr && rd !== m_read(int'(i))) begin
                n_fail++;
                $display("FAIL rnd_rd%0d idx=%0d got=%h exp=%h",
                         n, i, rd, m_read(int'(i)));
            end else if (wr && rd !== 32'h0) begin
                n_fail++;
                $display("FAIL rnd_wrdata%0d got=%h exp=0", n, rd);
            end
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        bus_idle();
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        @(negedge hclk);
        force dut.wcount_q = 16'hFFFF;
        #1 release dut.wcount_q;
        m_wc = 16'hFFFF;
        apb_xfer(1'b0, 4'd15, 32'h0, rd);
        n_checks++;
        if (rd !== 32'h0000_FFFF) begin
            n_fail++;
            $display("FAIL wrap_pre got=%h exp=ffff", rd);
        end
        apb_xfer(1'b1, 4'd7, 32'h7777_0007, rd);
        apb_xfer(1'b0, 4'd15, 32'h0, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_zero got=%h exp=0", rd);
        end
        apb_xfer(1'b1, 4'd15, 32'hFFFF_FFFF, rd);
        apb_xfer(1'b0, 4'd15, 32'h0, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL wrap_r15 got=%h exp=1", rd);
        end
        apb_xfer(1'b0, 4'd7, 32'h0, rd);
        n_checks++;
        if (rd !== 32'h7777_0007) begin
            n_fail++;
            $display("FAIL wrap_r7 got=%h exp=77770007", rd);
        end
        bus_idle();
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        @(negedge hclk);
        bus.pselx   = 3'b001;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 32'h14;
        bus.pwdata  = 32'h1234_5678;
        @(negedge hclk);
        bus.penable = 1'b1;
        #2 hresetn = 1'b0;
        m_reset();
        @(negedge hclk);
        bus.pselx   = 3'b000;
        bus.penable = 1'b0;
        #1 hresetn = 1'b1;
        bus_idle();
        apb_xfer(1'b0, 4'd5, 32'h0, rd);
        n_checks++;
        if (rd !== RV) begin
            n_fail++;
            $display("FAIL arst_r5 got=%h exp=%h", rd, RV);
        end
        apb_xfer(1'b0, 4'd15, 32'h0, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL arst_wc got=%h exp=0", rd);
        end
        bus_idle();
        // Another slave's transfers must be invisible here
        @(negedge hclk);
        bus.pselx   = 3'b010;
        bus.pwrite  = 1'b1;
        bus.paddr   = 32'h18;
        bus.pwdata  = 32'hDEAD_BEEF;
        @(negedge hclk);
        bus.penable = 1'b1;
        @(negedge hclk);
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        @(negedge hclk);
        bus.penable = 1'b1;
        #1;
        n_checks++;
        if (bus.prdata !== 32'h0) begin
            n_fail++;
            $display("FAIL other_prdata got=%h exp=0", bus.prdata);
        end
        bus_idle();
        n_checks++;
        if (bus.perr_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL other_irq got=%b exp=0", bus.perr_irq);
        end
        apb_xfer(1'b0, 4'd6, 32'h0, rd);
        n_checks++;
        if (rd !== RV) begin
            n_fail++;
            $display("FAIL other_r6 got=%h exp=%h", rd, RV);
        end
        apb_xfer(1'b0, 4'd15, 32'h0, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL other_wc got=%h exp=0", rd);
        end
        bus_idle();
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        hresetn     = 1'b0;
        bus.pselx   = 3'b000;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 32'h0;
        bus.pwdata  = 32'h0;
        m_reset();
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_err_no_setup();
        test_err_clear();
        test_random();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
